spawn_pos_gen: RTL and testbench

SPAWN_POS_GEN -- requirements
Module: spawn_pos_gen

---
 rtl/spawn_pkg.sv | 30 +++
 rtl/in_range.sv | 19 +
 rtl/spawn_pos_gen.sv | 134 +++++++++++++
 tb/tb_spawn_pos_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spawn_pkg.sv
// Shared definitions for the spawn position generator.
//   state_t        : FSM state encoding (IDLE, SAMP_X, SAMP_Y, CHECK, DONE)
//   OLED_* bounds  : default coordinate limits of the 96x64 OLED playfield
//   xcoord_t/ycoord_t/tries_t : datapath widths
//   sat_inc()      : saturating increment used for the retry counter
package spawn_pkg;

  localparam int OLED_XMIN = 0;
  localparam int OLED_XMAX = 95;
  localparam int OLED_YMIN = 0;
  localparam int OLED_YMAX = 63;

  typedef logic [6:0] xcoord_t;
  typedef logic [5:0] ycoord_t;
  typedef logic [7:0] tries_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMP_X = 3'd1,
    SAMP_Y = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic tries_t sat_inc(input tries_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/in_range.sv
// Unsigned range test and clamp for one coordinate.
//   value   : candidate sample
//   lo, hi  : inclusive bounds (lo <= hi)
//   ok      : value lies within [lo, hi]
//   clamped : value limited to [lo, hi]
module in_range #(
  parameter int W = 7
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         ok,
  output logic [W-1:0] clamped
);

  assign ok      = (value >= lo) && (value <= hi);
  assign clamped = (value < lo) ? lo : ((value > hi) ? hi : value);

endmodule

// File: rtl/spawn_pos_gen.sv
// Random spawn position generator. On request it samples an x and then a y
// coordinate from a free-running LFSR, rejecting samples outside the
// configured window and re-drawing when the pair repeats the previous output.
// A shared retry budget bounds the latency: once exhausted, out-of-range
// samples are clamped and a repeated position is accepted as is.
//   CLK    : clock, rising edge
//   RST    : asynchronous, active-high reset
//   lfsr_q : current LFSR state (x uses [6:0], y uses [5:0])
//   req    : level request, sampled only while idle
//   busy   : high whenever the generator is not idle
//   valid  : one-cycle pulse when x/y carry a new position
//   x, y   : last accepted position, held between pulses
module spawn_pos_gen
  import spawn_pkg::*;
#(
  parameter int XMIN      = OLED_XMIN,
  parameter int XMAX      = OLED_XMAX,  // XMIN <= XMAX <= 127
  parameter int YMIN      = OLED_YMIN,
  parameter int YMAX      = OLED_YMAX,  // YMIN <= YMAX <= 63
  parameter int MAX_TRIES = 16          // 1..255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] lfsr_q,
  input  logic        req,
  output logic        busy,
  output logic        valid,
  output logic [6:0]  x,
  output logic [5:0]  y
);

  localparam xcoord_t X_LO     = xcoord_t'(XMIN);
  localparam xcoord_t X_HI     = xcoord_t'(XMAX);
  localparam ycoord_t Y_LO     = ycoord_t'(YMIN);
  localparam ycoord_t Y_HI     = ycoord_t'(YMAX);
  localparam tries_t  TRY_LAST = tries_t'(MAX_TRIES - 1);

  state_t  state, state_nx;
  xcoord_t cand_x, cand_x_nx, x_clamped;
  ycoord_t cand_y, cand_y_nx, y_clamped;
  tries_t  tries, tries_nx;
  logic    x_ok, y_ok, last_try, same_pos;

  // Upper LFSR bits are not part of either coordinate.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[11:7];

  in_range #(.W(7)) u_x_range (
    .value   (lfsr_q[6:0]),
    .lo      (X_LO),
    .hi      (X_HI),
    .ok      (x_ok),
    .clamped (x_clamped)
  );

  in_range #(.W(6)) u_y_range (
    .value   (lfsr_q[5:0]),
    .lo      (Y_LO),
    .hi      (Y_HI),
    .ok      (y_ok),
    .clamped (y_clamped)
  );

  // The final try of the budget forces acceptance instead of another retry.
  assign last_try = (tries >= TRY_LAST);
  assign same_pos = (cand_x == x) && (cand_y == y);

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    cand_x_nx = cand_x;
    cand_y_nx = cand_y;
    tries_nx  = tries;

    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = SAMP_X;
          tries_nx = '0;
        end
      end
      SAMP_X: begin
        // Clamped equals the raw sample whenever it is in range.
        cand_x_nx = x_clamped;
        if (x_ok || last_try) state_nx = SAMP_Y;
        else                  tries_nx = sat_inc(tries);
      end
      SAMP_Y: begin
        cand_y_nx = y_clamped;
        if (y_ok || last_try) state_nx = CHECK;
        else                  tries_nx = sat_inc(tries);
      end
      CHECK: begin
        if (same_pos && !last_try) begin
          tries_nx = sat_inc(tries);
          state_nx = SAMP_X;
        end else begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cand_x <= '0;
      cand_y <= '0;
      tries  <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      x      <= X_LO;
      y      <= Y_LO;
    end else begin
      state  <= state_nx;
      cand_x <= cand_x_nx;
      cand_y <= cand_y_nx;
      tries  <= tries_nx;
      // Outputs are registered from the next state so they line up with it.
      busy   <= (state_nx != IDLE);
      valid  <= (state_nx == DONE);
      if (state_nx == DONE) begin
        x <= cand_x_nx;
        y <= cand_y_nx;
      end
    end
  end

endmodule

// File: tb/tb_spawn_pos_gen.sv
// Self-checking bench for spawn_pos_gen. One default instance and one with a
// narrowed window and a 4-try budget share clock, reset and LFSR stimulus.
// Expected positions are queued when a request is issued and compared by a
// monitor when valid pulses; scenario tasks check latency, busy and trace.
module tb_spawn_pos_gen;
  import spawn_pkg::*;

  typedef struct {
    logic [6:0] x;
    logic [5:0] y;
  } exp_t;

  logic        CLK, RST, req, req4;
  logic [11:0] lfsr_q;
  logic        busy, valid, busy4, valid4;
  logic [6:0]  x, x4;
  logic [5:0]  y, y4;

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  exp_t        sb4_q[$];
  exp_t        mon_e, mon4_e;
  logic [11:0] stim[$];

  spawn_pos_gen dut (
    .CLK(CLK), .RST(RST), .lfsr_q(lfsr_q), .req(req),
    .busy(busy), .valid(valid), .x(x), .y(y)
  );

  spawn_pos_gen #(.XMIN(16), .XMAX(95), .YMIN(8), .YMAX(40), .MAX_TRIES(4)) dut4 (
    .CLK(CLK), .RST(RST), .lfsr_q(lfsr_q), .req(req4),
    .busy(busy4), .valid(valid4), .x(x4), .y(y4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard monitors: every valid pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL dut_unexpected_valid: got x=%0d y=%0d, required no pulse", x, y);
      end else begin
        mon_e = sb_q.pop_front();
        if (x !== mon_e.x || y !== mon_e.y) begin
          errors++;
          $display("FAIL dut_position: got (%0d,%0d), required (%0d,%0d)", x, y, mon_e.x, mon_e.y);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (valid4 === 1'b1) begin
      checks++;
      if (sb4_q.size() == 0) begin
        errors++;
        $display("FAIL dut4_unexpected_valid: got x=%0d y=%0d, required no pulse", x4, y4);
      end else begin
        mon4_e = sb4_q.pop_front();
        if (x4 !== mon4_e.x || y4 !== mon4_e.y) begin
          errors++;
          $display("FAIL dut4_position: got (%0d,%0d), required (%0d,%0d)", x4, y4, mon4_e.x, mon4_e.y);
        end
      end
    end
  end

  // Issues one request, feeds stim[] one word per cycle from the first busy
  // cycle on (last word repeats), and checks latency, busy and SAMP_X count.
  task automatic do_request(input string name, input bit use4, input int exp_x,
                            input int exp_y, input int exp_lat, input int exp_sampx,
                            input int poke_at);
    exp_t   e;
    int     lat, nbusy, nsampx, k;
    state_t st;
    e.x = 7'(exp_x);
    e.y = 6'(exp_y);
    if (use4) sb4_q.push_back(e);
    else      sb_q.push_back(e);
    @(negedge CLK);
    if (use4) req4 = 1'b1;
    else      req  = 1'b1;
    @(negedge CLK);
    req = 1'b0; req4 = 1'b0;
    lat = 1; nbusy = 0; nsampx = 0; k = 0;
    forever begin
      st = use4 ? dut4.state : dut.state;
      if ((use4 ? busy4 : busy) === 1'b1) nbusy++;
      if (st == SAMP_X) nsampx++;
      if ((use4 ? valid4 : valid) === 1'b1 || lat >= 200) break;
      lfsr_q = stim[(k < stim.size()) ? k : stim.size() - 1];
      k++;
      if (lat == poke_at) begin
        if (use4) req4 = 1'b1;
        else      req  = 1'b1;
      end else begin
        req = 1'b0; req4 = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    req = 1'b0; req4 = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (nbusy != exp_lat) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, nbusy, exp_lat);
    end
    checks++;
    if (nsampx != exp_sampx) begin
      errors++;
      $display("FAIL %s_sampx_cycles: got %0d, required %0d", name, nsampx, exp_sampx);
    end
    @(negedge CLK);
    checks++;
    if ((use4 ? valid4 : valid) !== 1'b0 || (use4 ? busy4 : busy) !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got valid=%b busy=%b, required 0 0", name,
               use4 ? valid4 : valid, use4 ? busy4 : busy);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if ((use4 ? x4 : x) !== e.x || (use4 ? y4 : y) !== e.y) begin
      errors++;
      $display("FAIL %s_hold: got (%0d,%0d), required (%0d,%0d)", name,
               use4 ? x4 : x, use4 ? y4 : y, e.x, e.y);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req = 1'b0; req4 = 1'b0; lfsr_q = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || x !== 7'd0 || y !== 6'd0) begin
      errors++;
      $display("FAIL reset_dut: got busy=%b valid=%b x=%0d y=%0d, required 0 0 0 0", busy, valid, x, y);
    end
    checks++;
    if (busy4 !== 1'b0 || valid4 !== 1'b0 || x4 !== 7'd16 || y4 !== 6'd8) begin
      errors++;
      $display("FAIL reset_dut4: got busy=%b valid=%b x=%0d y=%0d, required 0 0 16 8", busy4, valid4, x4, y4);
    end
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b busy4=%b, required 0 0", busy, busy4);
    end
  endtask

  task automatic test_basic();
    stim = '{12'h050, 12'h025};
    do_request("basic", 1'b0, 80, 37, 4, 1, 0);
  endtask

  task automatic test_x_reject();
    stim = '{12'h064, 12'h064, 12'h064, 12'h00A, 12'h005};
    do_request("x_reject", 1'b0, 10, 5, 7, 4, 0);
  endtask

  task automatic test_repeat();
    stim = '{12'h00A, 12'h005, 12'h000, 12'h00B, 12'h005};
    do_request("repeat", 1'b0, 11, 5, 7, 2, 0);
  endtask

  task automatic test_req_while_busy();
    int pulses;
    stim = '{12'h033, 12'h03C};
    do_request("busy_req", 1'b0, 51, 60, 4, 1, 2);
    pulses = 0;
    repeat (6) begin
      @(negedge CLK);
      if (valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL busy_req_ignored: got %0d active cycles, required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses, last;
    stim = '{12'h028, 12'h014, 12'h000, 12'h000, 12'h000,
             12'h029, 12'h015, 12'h000, 12'h000, 12'h000,
             12'h02A, 12'h016, 12'h000, 12'h000, 12'h000};
    for (int i = 0; i < 3; i++) begin
      e.x = 7'(40 + i);
      e.y = 6'(20 + i);
      sb_q.push_back(e);
    end
    @(negedge CLK);
    req = 1'b1;
    pulses = 0; last = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (valid === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 5) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, required 5", c - last);
          end
        end else begin
          checks++;
          if (c != 3) begin
            errors++;
            $display("FAIL b2b_first: got pulse in cycle %0d, required 4", c + 1);
          end
        end
        pulses++;
        last = c;
      end
      lfsr_q = (c < stim.size()) ? stim[c] : 12'h000;
      if (c == 13) req = 1'b0;
    end
    repeat (6) begin
      @(negedge CLK);
      if (valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses busy=%b, required 3 pulses busy=0", pulses, busy);
    end
  endtask

  task automatic test_budget_dut4();
    stim = '{12'h07F};
    do_request("force_x", 1'b1, 95, 40, 7, 4, 0);
    stim = '{12'h003, 12'h014, 12'h002, 12'h002, 12'h009};
    do_request("y_reject", 1'b1, 20, 9, 7, 2, 0);
    stim = '{12'h01E, 12'h000};
    do_request("force_y", 1'b1, 30, 8, 7, 1, 0);
    stim = '{12'h01E, 12'h008, 12'h000, 12'h01E, 12'h008, 12'h000,
             12'h01E, 12'h008, 12'h000, 12'h01E, 12'h008};
    do_request("check_budget", 1'b1, 30, 8, 13, 4, 0);
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge CLK);
    req = 1'b1;
    @(negedge CLK);
    req = 1'b0; lfsr_q = 12'h040;
    @(negedge CLK);
    lfsr_q = 12'h03F;
    checks++;
    if (dut.state !== SAMP_Y) begin
      errors++;
      $display("FAIL rst_mid_state: got state %0d, required %0d", dut.state, SAMP_Y);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || x !== 7'd0 || y !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid_dut: got busy=%b valid=%b x=%0d y=%0d, required 0 0 0 0", busy, valid, x, y);
    end
    checks++;
    if (x4 !== 7'd16 || y4 !== 6'd8) begin
      errors++;
      $display("FAIL rst_mid_dut4: got x=%0d y=%0d, required 16 8", x4, y4);
    end
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge CLK);
      if (valid === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_mid_abort: got %0d active cycles, required 0", pulses);
    end
    stim = '{12'h050, 12'h025};
    do_request("after_rst", 1'b0, 80, 37, 4, 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_x_reject();
    test_repeat();
    test_req_while_busy();
    test_back_to_back();
    test_budget_dut4();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0 || sb4_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", sb_q.size(), sb4_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
